// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - command-driven sequencer for a bidirectional shift register
//
// Accepts one shift command at a time. A command can parallel-load the
// register, then shifts it left or right a programmed number of times with a
// fixed serial-in bit, presenting each exiting bit on ser_out. The final
// register contents are returned over a result handshake.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   cmd_valid/ready    command handshake (ready only while idle)
//   cmd_load/data      optional parallel load applied on accept
//   cmd_dir            1: shift left, 0: shift right
//   cmd_fill           serial-in bit used for every shift of the command
//   cmd_count          number of single-bit shifts (0 skips shifting)
//   ser_out/ser_valid  bit leaving the register in each shift cycle
//   res_valid/ready    result handshake
//   res_data           current register contents
//   busy               a command is in progress or its result is pending

module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic             cmd_fill,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dir_r, dir_nxt;
  logic             fill_r, fill_nxt;

  // Both shift candidates use the fill bit captured at accept time, so
  // later changes on cmd_fill cannot disturb a command in flight.
  logic [WIDTH-1:0] q_shl;
  logic [WIDTH-1:0] q_shr;

  assign q_shl = {q[WIDTH-2:0], fill_r};
  assign q_shr = {fill_r, q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      q      <= '0;
      cnt    <= '0;
      dir_r  <= 1'b0;
      fill_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      q      <= q_nxt;
      cnt    <= cnt_nxt;
      dir_r  <= dir_nxt;
      fill_r <= fill_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    cnt_nxt   = cnt;
    dir_nxt   = dir_r;
    fill_nxt  = fill_r;

    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          dir_nxt  = cmd_dir;
          fill_nxt = cmd_fill;
          if (cmd_load) begin
            q_nxt = cmd_data;
          end
          // A zero count goes straight to the result, so cnt is never
          // decremented from zero and cannot wrap.
          if (cmd_count == '0) begin
            state_nxt = S_DONE;
          end else begin
            cnt_nxt   = cmd_count;
            state_nxt = S_SHIFT;
          end
        end
      end

      S_SHIFT: begin
        q_nxt   = dir_r ? q_shl : q_shr;
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        // Returning to idle here means the next command waits one cycle.
        if (res_ready) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Every output is decoded from registered state only.
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign ser_valid = (state == S_SHIFT);
  assign ser_out   = ser_valid & (dir_r ? q[WIDTH-1] : q[0]);
  assign res_valid = (state == S_DONE);
  assign res_data  = q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - self-checking bench for shift_seq_ctrl

module tb_shift_seq_ctrl;

  localparam int W = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_load = 1'b0;
  logic [W-1:0]  cmd_data = '0;
  logic          cmd_dir = 1'b0;
  logic          cmd_fill = 1'b0;
  logic [CW-1:0] cmd_count = '0;
  logic          ser_out;
  logic          ser_valid;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [W-1:0]  res_data;
  logic          busy;

  int n_checks = 0;
  int n_fail = 0;

  shift_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_data(cmd_data), .cmd_dir(cmd_dir),
    .cmd_fill(cmd_fill), .cmd_count(cmd_count),
    .ser_out(ser_out), .ser_valid(ser_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: on accept, the whole command is unrolled into the list
  // of exiting bits and the register value after each shift.
  int m_q;
  int m_t;
  bit m_bits[$];
  int m_qs[$];
  bit m_done;

  initial begin
    m_q = 0;
    m_done = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q = 0;
        m_bits.delete();
        m_qs.delete();
        m_done = 0;
      end else if (m_bits.size() != 0) begin
        void'(m_bits.pop_front());
        m_q = m_qs.pop_front();
        if (m_bits.size() == 0) m_done = 1;
      end else if (m_done) begin
        if (res_ready) m_done = 0;
      end else if (cmd_valid) begin
        if (cmd_load) m_q = int'(cmd_data);
        m_t = m_q;
        for (int i = 0; i < int'(cmd_count); i++) begin
          if (cmd_dir) begin
            m_bits.push_back(m_t >= 8);
            m_t = (m_t * 2 + int'(cmd_fill)) % 16;
          end else begin
            m_bits.push_back(m_t % 2 == 1);
            m_t = m_t / 2 + int'(cmd_fill) * 8;
          end
          m_qs.push_back(m_t);
        end
        if (cmd_count == 0) m_done = 1;
      end
    end
  end

  bit e_idle;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        e_idle = (m_bits.size() == 0) && !m_done;
        check("cmd_ready", cmd_ready, e_idle);
        check("busy", busy, !e_idle);
        check("ser_valid", ser_valid, m_bits.size() != 0);
        check("ser_out", ser_out, (m_bits.size() != 0) ? m_bits[0] : 1'b0);
        check("res_valid", res_valid, m_done);
        check("res_data", res_data, m_q[W-1:0]);
      end
    end
  end

  task automatic issue(input logic ld, input logic [W-1:0] d, input logic dr,
                       input logic fl, input logic [CW-1:0] c);
    int g;
    g = 0;
    cmd_load = ld; cmd_data = d; cmd_dir = dr; cmd_fill = fl; cmd_count = c;
    cmd_valid = 1'b1;
    while (!cmd_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    check("issue_wait_bound", g < 50, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_data = W'($urandom);
    cmd_fill = 1'($urandom);
    cmd_dir = 1'($urandom);
    cmd_count = CW'($urandom);
  endtask

  task automatic run_cmd(input logic ld, input logic [W-1:0] d, input logic dr,
                         input logic fl, input logic [CW-1:0] c,
                         output logic [7:0] bits, output int nser, output int lat,
                         output logic [W-1:0] res);
    issue(ld, d, dr, fl, c);
    bits = '0; nser = 0; lat = 0;
    while (!res_valid && lat < 40) begin
      if (ser_valid && nser < 8) begin
        bits[nser] = ser_out;
        nser++;
      end
      @(posedge clk); #1; lat++;
    end
    check("result_wait_bound", lat < 40, 1);
    res = res_data;
  endtask

  task automatic ret();
    int g;
    g = 0;
    while (!res_valid && g < 50) begin
      @(posedge clk); #1; g++;
    end
    check("ret_wait_bound", g < 50, 1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  logic [7:0]   bits;
  int           nser;
  int           lat;
  logic [W-1:0] res;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("por_res_data", res_data, 0);
    check("por_cmd_ready", cmd_ready, 1);
    check("por_busy", busy, 0);
    check("por_ser_valid", ser_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Left shift by one
    run_cmd(1, 4'b1011, 1, 0, 1, bits, nser, lat, res);
    check("left_nser", nser, 1);
    check("left_bits", bits[0], 1);
    check("left_lat", lat, 1);
    check("left_res", res, 4'b0110);
    ret();

    // Asynchronous reset mid-cycle from idle with a nonzero register
    check("pre_reset_q", res_data, 4'b0110);
    #2 rst = 1'b1;
    #1;
    check("rst_idle_res_data", res_data, 0);
    check("rst_idle_cmd_ready", cmd_ready, 1);
    check("rst_idle_busy", busy, 0);
    check("rst_idle_ser_valid", ser_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Right shift by two with fill 1
    run_cmd(1, 4'b1011, 0, 1, 2, bits, nser, lat, res);
    check("right_nser", nser, 2);
    check("right_bits", bits[1:0], 2'b11);
    check("right_lat", lat, 2);
    check("right_res", res, 4'b1110);
    ret();

    // Zero count
    run_cmd(1, 4'b0101, 1, 1, 0, bits, nser, lat, res);
    check("zero_nser", nser, 0);
    check("zero_lat", lat, 0);
    check("zero_ser_valid", ser_valid, 0);
    check("zero_res", res, 4'b0101);
    ret();

    // Backpressure with a competing command, then operate on held result
    run_cmd(1, 4'b1011, 1, 0, 1, bits, nser, lat, res);
    check("bp_setup_res", res, 4'b0110);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_load = 1'b1; cmd_data = 4'b1001;
      cmd_dir = 1'($urandom); cmd_fill = 1'($urandom); cmd_count = 3'd3;
      @(posedge clk); #1;
      check("bp_res_data", res_data, 4'b0110);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_res_valid", res_valid, 1);
    end
    cmd_valid = 1'b0;
    ret();
    run_cmd(0, 4'b0000, 1, 1, 2, bits, nser, lat, res);
    check("hold_nser", nser, 2);
    check("hold_bits", bits[1:0], 2'b10);
    check("hold_res", res, 4'b1011);
    ret();

    // Count larger than the register width
    run_cmd(1, 4'b1111, 0, 0, 7, bits, nser, lat, res);
    check("over_nser", nser, 7);
    check("over_bits", bits[6:0], 7'b0001111);
    check("over_lat", lat, 7);
    check("over_res", res, 4'b0000);
    ret();

    // Reset while shifting aborts the command
    issue(1, 4'b1010, 1, 1, 7);
    @(posedge clk); #1;
    check("mid_shift_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_shift_busy", busy, 0);
    check("rst_shift_res_valid", res_valid, 0);
    check("rst_shift_ser_valid", ser_valid, 0);
    check("rst_shift_res_data", res_data, 0);
    check("rst_shift_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 800; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_load  = 1'($urandom_range(0, 1));
      cmd_data  = W'($urandom);
      cmd_dir   = 1'($urandom);
      cmd_fill  = 1'($urandom);
      cmd_count = CW'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      if (i == 400) begin
        #2 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("final_idle", cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Command-driven sequencer for a bidirectional WIDTH-bit shift register. It accepts one shift command at a time over a valid/ready handshake. Each command can optionally parallel-load the register, then shift it left or right by a programmed count while presenting each exiting bit serially. The final register contents are returned over a second valid/ready handshake. It sits between a host/control FSM and the serial shift datapath in the Shift Register group, replacing hand-driven direction and serial-input pins with a counted, handshaked operation.

## Interface
Parameters:
- WIDTH, 4, register width in bits (>=2)
- CNT_W, 3, width of the shift-count field; counts 0..2^CNT_W-1; counts larger than WIDTH are legal

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command (high only in IDLE)
- cmd_load  input  1  1: load cmd_data into the register on accept; 0: keep the current register contents
- cmd_data  input  WIDTH  parallel load value
- cmd_dir  input  1  1: left shift, q <= {q[WIDTH-2:0], fill}; 0: right shift, q <= {fill, q[WIDTH-1:1]}
- cmd_fill  input  1  serial-in bit, captured on accept and used for every shift of the command
- cmd_count  input  CNT_W  number of single-bit shifts
- ser_out  output  1  bit leaving the register this cycle: q[WIDTH-1] when shifting left, q[0] when shifting right; 0 outside SHIFT
- ser_valid  output  1  high in every SHIFT cycle
- res_valid  output  1  result available (DONE)
- res_ready  input  1  consumer takes the result
- res_data  output  WIDTH  register contents (always equal to the internal q)
- busy  output  1  state != IDLE

## Operation
- States: IDLE, SHIFT, DONE (2-bit encoding).
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, capture dir, fill and count.
  - If cmd_load, q <= cmd_data.
  - If count==0, go to DONE. Otherwise go to SHIFT with cnt <= count.
- SHIFT:
  - Each cycle, q shifts one position in the captured direction with the captured fill bit.
  - ser_out shows the bit leaving the register.
  - cnt <= cnt-1. When cnt==1, this is the last shift; go to DONE.
- DONE:
  - res_valid=1 and res_data=q.
  - On res_ready, go to IDLE.
  - No new command is accepted in the same cycle.
- cmd_valid outside IDLE is ignored. cmd_* inputs are sampled only on the accept edge; later changes have no effect.
- res_data holds q across backpressure. q is retained after return to IDLE, so a following cmd_load=0 command operates on the previous result.
- cnt is CNT_W bits wide. It never wraps, because the count==0 case bypasses SHIFT.

## Timing
- Reset (asynchronous, any state): state=IDLE, q=0, cnt=0, captured dir/fill=0.
  - Outputs: cmd_ready=1, ser_out=0, ser_valid=0, res_valid=0, res_data=0, busy=0.
  - Reset mid-SHIFT aborts the command; no result is produced.
- Command accepted at edge T with count N>0:
  - SHIFT occupies cycles T..T+N-1 (after edges T..T+N-1).
  - Shifts happen at edges T+1..T+N.
  - res_valid rises after edge T+N.
- Command accepted at edge T with count 0: res_valid rises after edge T. res_data equals the loaded or held q.
- Result returned at edge R (res_valid&res_ready): IDLE after edge R. The next command can be accepted at edge R+1 at the earliest.
- Throughput: N+2 cycles per command with no backpressure.
- All outputs are decoded from registered state and q. There are no combinational paths from inputs to outputs.

## Test plan
- Reset checks:
  - Assert rst asynchronously mid-cycle from idle, then deassert. Required: res_data=0, cmd_ready=1, busy=0, ser_valid=0.
  - Assert rst in SHIFT. Required: immediate return to IDLE, q=0, no res_valid.
- Left shift: load 4'b1011, dir=1, fill=0, count=1. Required: ser_out=1 for one cycle, then res_data=4'b0110 and res_valid 2 cycles after accept.
- Right shift: load 4'b1011, dir=0, fill=1, count=2. Required: ser_out 1 then 1, res_data=4'b1110, res_valid 3 cycles after accept.
- Zero count: load 4'b0101, count=0. Required: ser_valid never high, res_valid the cycle after accept, res_data=4'b0101.
- Backpressure and hold:
  - Hold res_ready=0 for 5 cycles while driving cmd_valid. Required: res_data stable, cmd_ready=0, command not taken.
  - Then release res_ready and issue cmd_load=0, dir=1, fill=1, count=2 on the held result 4'b0110. Required: res_data=4'b1011.
- Over-length count: load 4'b1111, dir=0, fill=0, count=7. Required: 7 ser_valid cycles with ser_out 1,1,1,1,0,0,0, res_data=4'b0000.
